// File: rtl/sgd_x_rd_pkg.sv
// Shared definitions for the model-x read path: x BRAM geometry, bank
// grouping and the 3-bit state encodings of the read controller.
package sgd_x_rd_pkg;

  localparam int X_BIT_DEPTH        = 12;  // x BRAM address width
  localparam int NUM_BITS_PER_BANK  = 8;   // 32-bit lanes per x BRAM word
  localparam int BIT_WIDTH_OF_BANK  = 6;   // log2 of features per x BRAM word
  localparam int NUM_OF_BANKS       = 8;   // samples admitted per credit
  localparam int NUM_OF_BANKS_WIDTH = 3;   // log2(NUM_OF_BANKS)
  localparam int X_BRAM_LAT         = 2;   // x BRAM read latency in cycles

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_STARTING    = 3'd1,
    ST_EPOCH       = 3'd2,
    ST_WAIT_CREDIT = 3'd3,
    ST_READ        = 3'd4,
    ST_FINISH      = 3'd5
  } state_t;

endpackage

// File: rtl/sgd_valid_delay_line.sv
// Delays the {valid, last} tag of each x BRAM read by the BRAM read latency
// so both arrive together with the returned data word.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   vld_in, last_in     read strobe and final-chunk tag at issue time
//   vld_out, last_out   the same tags DEPTH cycles later
module sgd_valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_in,
  input  logic last_in,
  output logic vld_out,
  output logic last_out
);

  logic [DEPTH-1:0] vld_p;
  logic [DEPTH-1:0] last_p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p  <= '0;
      last_p <= '0;
    end else begin
      vld_p[0]  <= vld_in;
      last_p[0] <= last_in;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i]  <= vld_p[i-1];
        last_p[i] <= last_p[i-1];
      end
    end
  end

  assign vld_out  = vld_p[DEPTH-1];
  assign last_out = last_p[DEPTH-1];

endmodule

// File: rtl/sgd_x_rd.sv
// Read-side consumer of the model-x credit protocol. Each credit published
// by the x writer admits one bank-group of samples; for each admitted group
// the controller issues one full pass of x BRAM chunk reads (0..chunks-1)
// to the dot-product pipeline under backpressure, and returns the BRAM data
// tagged with valid and last-chunk so the consumer never sees a stale model.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   started                  job start level (re-timed through two flops)
//   dimension                feature count
//   number_of_epochs         epochs to run (bits [9:0])
//   number_of_samples        samples per epoch, multiple of BANKS
//   x_wr_credit_counter      cumulative writer credits, wraps mod 256
//   x_rd_ready               downstream can accept a read this cycle
//   x_rd_en, x_rd_addr       BRAM read strobe and chunk address
//   x_rd_data                BRAM read data
//   x_out_valid/data/last    aligned chunk output with final-chunk tag
//   sgd_x_rd_done            all epochs consumed (sticky)
//   sgd_x_rd_error           protocol or configuration error (sticky)
//   state_counters_x_rd      {x_rd_en, state, group_index[19:0], epoch_index[7:0]}
module sgd_x_rd
  import sgd_x_rd_pkg::*;
#(
  parameter int ADDR_W     = X_BIT_DEPTH,
  parameter int DATA_W     = NUM_BITS_PER_BANK * 32,
  parameter int CHUNK_LOG2 = BIT_WIDTH_OF_BANK,
  parameter int BANKS      = NUM_OF_BANKS,
  parameter int BRAM_LAT   = X_BRAM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              started,
  input  logic [31:0]       dimension,
  input  logic [31:0]       number_of_epochs,
  input  logic [31:0]       number_of_samples,
  input  logic [7:0]        x_wr_credit_counter,
  input  logic              x_rd_ready,
  output logic              x_rd_en,
  output logic [ADDR_W-1:0] x_rd_addr,
  input  logic [DATA_W-1:0] x_rd_data,
  output logic              x_out_valid,
  output logic [DATA_W-1:0] x_out_data,
  output logic              x_out_last,
  output logic              sgd_x_rd_done,
  output logic              sgd_x_rd_error,
  output logic [31:0]       state_counters_x_rd
);

  localparam int BANK_SHIFT = $clog2(BANKS);

  // Number of BRAM words covering `dim` features (ceiling division).
  function automatic logic [31:0] ceil_chunks(input logic [31:0] dim);
    return (dim >> CHUNK_LOG2) + {31'd0, |dim[CHUNK_LOG2-1:0]};
  endfunction

  logic [31:0] chunks_p0, chunks_p1;
  logic [31:0] groups_p0, groups_p1;
  logic [9:0]  epochs_p0, epochs_p1;
  logic [21:0] unused_epoch_hi;

  logic        started_r1, started_r2;
  logic [7:0]  credit_r;
  logic [7:0]  consumed;
  logic [7:0]  avail;

  state_t      state;
  logic [31:0] chunk_index;
  logic [31:0] group_index;
  logic [9:0]  epoch_index;
  logic [31:0] last_chunk;
  logic        rd_last;
  logic        done_r;
  logic        error_r;

  assign unused_epoch_hi = number_of_epochs[31:10];

  // ---- config capture stage 0 -> stage 1 (stable before STARTING) ----
  always_ff @(posedge clk) begin
    chunks_p0 <= ceil_chunks(dimension);
    groups_p0 <= number_of_samples >> BANK_SHIFT;
    epochs_p0 <= number_of_epochs[9:0];
    chunks_p1 <= chunks_p0;
    groups_p1 <= groups_p0;
    epochs_p1 <= epochs_p0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      started_r1 <= 1'b0;
      started_r2 <= 1'b0;
      credit_r   <= '0;
    end else begin
      started_r1 <= started;
      started_r2 <= started_r1;
      credit_r   <= x_wr_credit_counter;
    end
  end

  // Wrapping difference; bit 7 set means we have consumed past the writer.
  assign avail      = credit_r - consumed;
  assign last_chunk = chunks_p1 - 32'd1;

  // ---- control FSM ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      chunk_index <= '0;
      group_index <= '0;
      epoch_index <= '0;
      consumed    <= '0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (started_r2) state <= ST_STARTING;
        end
        ST_STARTING: begin
          epoch_index <= '0;
          consumed    <= '0;
          done_r      <= 1'b0;
          error_r     <= 1'b0;
          if (chunks_p1 == '0 || groups_p1 == '0) begin
            error_r <= 1'b1;
            state   <= ST_FINISH;
          end else begin
            state <= ST_EPOCH;
          end
        end
        ST_EPOCH: begin
          group_index <= '0;
          if (epoch_index == epochs_p1) begin
            state <= ST_FINISH;
          end else begin
            epoch_index <= epoch_index + 10'd1;
            state       <= ST_WAIT_CREDIT;
          end
        end
        ST_WAIT_CREDIT: begin
          if (avail[7]) begin
            error_r <= 1'b1;
            state   <= ST_FINISH;
          end else if (group_index == groups_p1) begin
            state <= ST_EPOCH;
          end else if (avail != '0) begin
            consumed    <= consumed + 8'd1;
            chunk_index <= '0;
            state       <= ST_READ;
          end
        end
        ST_READ: begin
          if (x_rd_ready) begin
            if (chunk_index == last_chunk) begin
              chunk_index <= '0;
              group_index <= group_index + 32'd1;
              state       <= ST_WAIT_CREDIT;
            end else begin
              chunk_index <= chunk_index + 32'd1;
            end
          end
        end
        ST_FINISH: begin
          done_r <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign x_rd_en   = (state == ST_READ) && x_rd_ready;
  assign x_rd_addr = chunk_index[ADDR_W-1:0];
  assign rd_last   = x_rd_en && (chunk_index == last_chunk);

  // ---- issue -> return: tags ride the BRAM latency ----
  sgd_valid_delay_line #(
    .DEPTH (BRAM_LAT)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld_in   (x_rd_en),
    .last_in  (rd_last),
    .vld_out  (x_out_valid),
    .last_out (x_out_last)
  );

  // Data word is captured on the same edge its valid reaches the output.
  always_ff @(posedge clk) begin
    x_out_data <= x_rd_data;
  end

  assign sgd_x_rd_done       = done_r;
  assign sgd_x_rd_error      = error_r;
  assign state_counters_x_rd = {x_rd_en, state, group_index[19:0], epoch_index[7:0]};

endmodule

// File: tb/tb_sgd_x_rd.sv
// Directed bench for sgd_x_rd: a table of job configurations with expected
// read counts and error outcome, plus hand-written sequences for credit
// latency, mod-256 credit wrap, credit underflow and reset during READ.
// The BRAM model updates its output register on the edge after the read
// strobe; the DUT's capture register completes the two-cycle read latency.
module tb_sgd_x_rd;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst_n;
  logic              started;
  logic [31:0]       dimension;
  logic [31:0]       number_of_epochs;
  logic [31:0]       number_of_samples;
  logic [7:0]        x_wr_credit_counter;
  logic              x_rd_ready;
  logic              x_rd_en;
  logic [ADDR_W-1:0] x_rd_addr;
  logic [DATA_W-1:0] x_rd_data;
  logic              x_out_valid;
  logic [DATA_W-1:0] x_out_data;
  logic              x_out_last;
  logic              sgd_x_rd_done;
  logic              sgd_x_rd_error;
  logic [31:0]       state_counters_x_rd;

  sgd_x_rd dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .started             (started),
    .dimension           (dimension),
    .number_of_epochs    (number_of_epochs),
    .number_of_samples   (number_of_samples),
    .x_wr_credit_counter (x_wr_credit_counter),
    .x_rd_ready          (x_rd_ready),
    .x_rd_en             (x_rd_en),
    .x_rd_addr           (x_rd_addr),
    .x_rd_data           (x_rd_data),
    .x_out_valid         (x_out_valid),
    .x_out_data          (x_out_data),
    .x_out_last          (x_out_last),
    .sgd_x_rd_done       (sgd_x_rd_done),
    .sgd_x_rd_error      (sgd_x_rd_error),
    .state_counters_x_rd (state_counters_x_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pat(input int a);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(a);
    return {8{w}};
  endfunction

  initial x_rd_data = '0;
  always @(posedge clk) begin
    if (x_rd_en) x_rd_data <= pat(int'(x_rd_addr));
  end

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt, out_cnt, exp_rd_addr, exp_out_addr, cur_chunks;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted read and every returned chunk must follow
  // 0..chunks-1 in order, with last on the final chunk.
  task automatic monitor();
    if (x_rd_en) begin
      check("rd_addr", 64'(x_rd_addr), 64'(exp_rd_addr));
      exp_rd_addr = (exp_rd_addr >= cur_chunks - 1) ? 0 : exp_rd_addr + 1;
      rd_cnt++;
    end
    if (x_out_valid) begin
      n_checks++;
      if (x_out_data !== pat(exp_out_addr)) begin
        n_fail++;
        $display("FAIL out_data: got %h expected %h", x_out_data, pat(exp_out_addr));
      end
      check("out_last", 64'(x_out_last), 64'(exp_out_addr == cur_chunks - 1));
      exp_out_addr = (exp_out_addr >= cur_chunks - 1) ? 0 : exp_out_addr + 1;
      out_cnt++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    rd_cnt = 0; out_cnt = 0; exp_rd_addr = 0; exp_out_addr = 0;
  endtask

  task automatic start_job(input logic [31:0] dim, input logic [31:0] smp, input logic [31:0] ep);
    rst_n = 1'b0; started = 1'b0; x_wr_credit_counter = 8'd0; x_rd_ready = 1'b1;
    dimension = dim; number_of_samples = smp; number_of_epochs = ep;
    cur_chunks = int'((64'(dim) + 64'd63) / 64'd64);
    tick(); tick();
    clear_sb();
    rst_n = 1'b1; started = 1'b1;
  endtask

  task automatic wait_reads(input string name, input int n, input int budget);
    for (int i = 0; i < budget && rd_cnt < n; i++) tick();
    check(name, 64'(rd_cnt), 64'(n));
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && !sgd_x_rd_done; i++) tick();
    check(name, 64'(sgd_x_rd_done), 64'd1);
  endtask

  typedef struct {
    logic [31:0] dim;
    logic [31:0] smp;
    logic [31:0] ep;
    int          credits;
    bit          toggle;
    int          exp_reads;
    bit          exp_err;
  } vec_t;

  vec_t        vecs[8];
  logic [3:0]  rpat;
  int          given, extra;

  initial begin
    rpat = 4'b1001;  // ready sequence 1,0,0,1 repeating
    vecs[0] = '{32'd128,  32'd16, 32'd1, 2, 1'b0, 4,  1'b0};
    vecs[1] = '{32'd200,  32'd8,  32'd1, 1, 1'b1, 4,  1'b0};
    vecs[2] = '{32'd64,   32'd24, 32'd2, 6, 1'b0, 6,  1'b0};
    vecs[3] = '{32'd0,    32'd16, 32'd1, 0, 1'b0, 0,  1'b1};
    vecs[4] = '{32'd64,   32'd0,  32'd1, 0, 1'b0, 0,  1'b1};
    vecs[5] = '{32'd64,   32'd8,  32'd0, 0, 1'b0, 0,  1'b0};
    vecs[6] = '{32'd65,   32'd16, 32'd1, 2, 1'b1, 4,  1'b0};
    vecs[7] = '{32'd4096, 32'd8,  32'd1, 1, 1'b0, 64, 1'b0};

    rst_n = 1'b0; started = 1'b0; x_wr_credit_counter = 8'd0; x_rd_ready = 1'b1;
    dimension = 32'd128; number_of_samples = 32'd16; number_of_epochs = 32'd1;
    cur_chunks = 2;
    clear_sb();
    tick(); tick();

    // Reset state
    check("rst_rd_en",  64'(x_rd_en), 64'd0);
    check("rst_addr",   64'(x_rd_addr), 64'd0);
    check("rst_valid",  64'(x_out_valid), 64'd0);
    check("rst_last",   64'(x_out_last), 64'd0);
    check("rst_done",   64'(sgd_x_rd_done), 64'd0);
    check("rst_error",  64'(sgd_x_rd_error), 64'd0);
    check("rst_state",  64'(state_counters_x_rd[30:28]), 64'd0);

    // Table-driven job configurations
    for (int v = 0; v < 8; v++) begin
      start_job(vecs[v].dim, vecs[v].smp, vecs[v].ep);
      given = 0; extra = 0;
      for (int i = 0; i < 2000 && extra < 6; i++) begin
        x_rd_ready = vecs[v].toggle ? rpat[i[1:0]] : 1'b1;
        if ((i % 16) == 15 && given < vecs[v].credits) begin
          given++;
          x_wr_credit_counter = 8'(given);
        end
        tick();
        if (sgd_x_rd_done) extra++;
      end
      x_rd_ready = 1'b1;
      check($sformatf("vec%0d_done", v),  64'(sgd_x_rd_done), 64'd1);
      check($sformatf("vec%0d_error", v), 64'(sgd_x_rd_error), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_reads", v), 64'(rd_cnt), 64'(vecs[v].exp_reads));
      check($sformatf("vec%0d_outs", v),  64'(out_cnt), 64'(vecs[v].exp_reads));
      check($sformatf("vec%0d_state", v), 64'(state_counters_x_rd[30:28]), 64'd5);
    end

    // Credit latency: no reads while starved, first read 2 cycles after credit
    start_job(32'd128, 32'd16, 32'd1);
    for (int i = 0; i < 50; i++) tick();
    check("starved_no_rd", 64'(rd_cnt), 64'd0);
    x_wr_credit_counter = 8'd1;
    tick();
    check("lat_cyc1_rd_en", 64'(x_rd_en), 64'd0);
    tick();
    check("lat_cyc2_rd_en", 64'(x_rd_en), 64'd1);
    check("lat_cyc2_addr",  64'(x_rd_addr), 64'd0);
    tick();
    check("lat_cyc3_valid", 64'(x_out_valid), 64'd0);
    tick();
    check("lat_cyc4_valid", 64'(x_out_valid), 64'd1);
    check("lat_cyc4_last",  64'(x_out_last), 64'd0);
    tick();
    check("lat_cyc5_last",  64'(x_out_last), 64'd1);
    x_wr_credit_counter = 8'd2;
    wait_done("lat_done", 100);
    for (int i = 0; i < 4; i++) tick();
    check("lat_outs",  64'(out_cnt), 64'd4);
    check("lat_error", 64'(sgd_x_rd_error), 64'd0);

    // Credit wrap: consume up to 254, then step 255 -> 0 -> 1
    start_job(32'd64, 32'd2056, 32'd1);
    x_wr_credit_counter = 8'd100;
    wait_reads("wrap_100", 100, 400);
    x_wr_credit_counter = 8'd200;
    wait_reads("wrap_200", 200, 400);
    x_wr_credit_counter = 8'd254;
    wait_reads("wrap_254", 254, 300);
    check("wrap_err_254", 64'(sgd_x_rd_error), 64'd0);
    x_wr_credit_counter = 8'd255;
    wait_reads("wrap_255", 255, 20);
    x_wr_credit_counter = 8'd0;
    wait_reads("wrap_0", 256, 20);
    x_wr_credit_counter = 8'd1;
    wait_reads("wrap_1", 257, 20);
    wait_done("wrap_done", 40);
    check("wrap_error", 64'(sgd_x_rd_error), 64'd0);

    // Writer counter falling behind consumed -> error and finish
    start_job(32'd64, 32'd24, 32'd1);
    x_wr_credit_counter = 8'd1;
    wait_reads("under_first", 1, 50);
    x_wr_credit_counter = 8'd0;
    wait_done("under_done", 20);
    check("under_error", 64'(sgd_x_rd_error), 64'd1);
    check("under_reads", 64'(rd_cnt), 64'd1);

    // Reset in the middle of a 10-chunk group, then a clean restart
    start_job(32'd640, 32'd8, 32'd1);
    x_wr_credit_counter = 8'd1;
    wait_reads("mid_reads", 3, 60);
    rst_n = 1'b0; started = 1'b0; x_wr_credit_counter = 8'd0;
    tick();
    check("mid_rst_rd_en", 64'(x_rd_en), 64'd0);
    check("mid_rst_valid", 64'(x_out_valid), 64'd0);
    check("mid_rst_last",  64'(x_out_last), 64'd0);
    check("mid_rst_state", 64'(state_counters_x_rd[30:28]), 64'd0);
    check("mid_rst_done",  64'(sgd_x_rd_done), 64'd0);
    clear_sb();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid_quiet_outs", 64'(out_cnt), 64'd0);
    check("mid_quiet_reads", 64'(rd_cnt), 64'd0);
    started = 1'b1; x_wr_credit_counter = 8'd1;
    wait_done("restart_done", 100);
    for (int i = 0; i < 4; i++) tick();
    check("restart_reads", 64'(rd_cnt), 64'd10);
    check("restart_outs",  64'(out_cnt), 64'd10);
    check("restart_error", 64'(sgd_x_rd_error), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
